// File: rtl/op_sequencer.sv
// op_sequencer: SM83 instruction sequencer.
// Owns the instruction register, micro-step counter, CB-prefix mode, IME with
// one-opcode EI delay, HALT and vectored interrupt dispatch. It feeds
// ir/step/cb_mode/int_mode to the decoder.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   d_in                data bus (opcode byte at fetch)
//   done                decoder: last step of current opcode
//   is_cond/cond        decoder: conditional step, 0=NZ 1=Z 2=NC 3=C
//   next_cond           step loaded when the condition is not met
//   f_z, f_c            current Z/C flags
//   halt_req/ei/di/reti decoder opcode class, sampled with done
//   irq_pending         IE & IF, level, bit 0 highest priority
//   ir, step, cb_mode   decoder context
//   int_mode, halted    dispatch in progress / core halted
//   ime                 interrupt master enable
//   irq_ack             one-hot single-cycle IF clear pulse
//   irq_vec             dispatch vector, valid while int_mode
module op_sequencer #(
  parameter int unsigned STEP_W    = 3,
  parameter int unsigned NUM_IRQ   = 5,
  parameter int unsigned INT_STEPS = 5,
  parameter logic [7:0]  VEC_BASE  = 8'h40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          d_in,
  input  logic                done,
  input  logic                is_cond,
  input  logic [1:0]          cond,
  input  logic [STEP_W-1:0]   next_cond,
  input  logic                f_z,
  input  logic                f_c,
  input  logic                halt_req,
  input  logic                ei,
  input  logic                di,
  input  logic                reti,
  input  logic [NUM_IRQ-1:0]  irq_pending,
  output logic [7:0]          ir,
  output logic [STEP_W-1:0]   step,
  output logic                cb_mode,
  output logic                int_mode,
  output logic                halted,
  output logic                ime,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [7:0]          irq_vec
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_INT  = 2'd2;

  localparam logic [STEP_W-1:0] STEP_INC  = {{(STEP_W-1){1'b0}}, 1'b1};
  // Ack/vector are registered on the edge that enters step 2 so they are
  // visible together with step==2.
  localparam logic [STEP_W-1:0] STEP_PRE_ACK = STEP_INC;
  localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(INT_STEPS - 1);

  logic [1:0]         state;
  logic               ei_pend;
  logic               cond_met;
  logic               ime_eff;
  logic               irq_any;
  logic               ime_upd;
  logic               ep_upd;
  logic               found;
  logic [NUM_IRQ-1:0] ack_n;
  logic [7:0]         vec_n;

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      2'd0: cond_met = !f_z;
      2'd1: cond_met = f_z;
      2'd2: cond_met = !f_c;
      2'd3: cond_met = f_c;
      default: cond_met = 1'b0;
    endcase
  end

  assign irq_any = |irq_pending;
  // DI takes effect on this very done; a pending EI does not.
  assign ime_eff = ime && !di;

  // IME bookkeeping at done; DI is applied last so it cancels everything.
  always_comb begin
    ime_upd = ime;
    ep_upd  = ei_pend;
    if (ei_pend) begin
      ime_upd = 1'b1;
      ep_upd  = 1'b0;
    end
    if (ei)   ep_upd  = 1'b1;
    if (reti) ime_upd = 1'b1;
    if (di) begin
      ime_upd = 1'b0;
      ep_upd  = 1'b0;
    end
  end

  // Lowest set pending bit wins.
  always_comb begin
    found = 1'b0;
    ack_n = '0;
    vec_n = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_pending[i] && !found) begin
        found    = 1'b1;
        ack_n[i] = 1'b1;
        vec_n    = VEC_BASE + 8'(i << 3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_RUN;
      ir       <= '0;
      step     <= '0;
      cb_mode  <= 1'b0;
      int_mode <= 1'b0;
      halted   <= 1'b0;
      ime      <= 1'b0;
      ei_pend  <= 1'b0;
      irq_ack  <= '0;
      irq_vec  <= '0;
    end else begin
      irq_ack <= '0;
      case (state)
        S_RUN: begin
          if (!done) begin
            step <= (is_cond && !cond_met) ? next_cond : step + STEP_INC;
          end else begin
            ei_pend <= ep_upd;
            step    <= '0;
            if (ime_eff && irq_any) begin
              state    <= S_INT;
              int_mode <= 1'b1;
              ime      <= 1'b0;
              cb_mode  <= 1'b0;
            end else begin
              ime <= ime_upd;
              if (halt_req) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end else begin
                ir      <= d_in;
                cb_mode <= (ir == 8'hCB) && !cb_mode;
              end
            end
          end
        end
        S_HALT: begin
          step <= '0;
          if (irq_any) begin
            halted <= 1'b0;
            if (ime) begin
              state    <= S_INT;
              int_mode <= 1'b1;
              ime      <= 1'b0;
            end else begin
              state   <= S_RUN;
              ir      <= d_in;
              cb_mode <= 1'b0;
            end
          end
        end
        S_INT: begin
          step <= step + STEP_INC;
          if (step == STEP_PRE_ACK) begin
            irq_ack <= ack_n;
            irq_vec <= vec_n;
          end
          if (step == STEP_LAST) begin
            state    <= S_RUN;
            ir       <= d_in;
            step     <= '0;
            int_mode <= 1'b0;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: self-checking bench for op_sequencer.
// Per-cycle stimulus/expectation records are applied in order; each record's
// expected outputs go through a scoreboard queue and are compared #1 after
// the clock edge. A final hand-written sequence covers HALT-to-dispatch with
// bounded waits.
module tb_op_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] d_in;
  logic       done;
  logic       is_cond;
  logic [1:0] cond;
  logic [2:0] next_cond;
  logic       f_z;
  logic       f_c;
  logic       halt_req;
  logic       ei;
  logic       di;
  logic       reti;
  logic [4:0] irq_pending;
  logic [7:0] ir;
  logic [2:0] step;
  logic       cb_mode;
  logic       int_mode;
  logic       halted;
  logic       ime;
  logic [4:0] irq_ack;
  logic [7:0] irq_vec;

  op_sequencer #(
    .STEP_W(3),
    .NUM_IRQ(5),
    .INT_STEPS(5),
    .VEC_BASE(8'h40)
  ) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .done(done), .is_cond(is_cond),
    .cond(cond), .next_cond(next_cond), .f_z(f_z), .f_c(f_c),
    .halt_req(halt_req), .ei(ei), .di(di), .reti(reti),
    .irq_pending(irq_pending), .ir(ir), .step(step), .cb_mode(cb_mode),
    .int_mode(int_mode), .halted(halted), .ime(ime), .irq_ack(irq_ack),
    .irq_vec(irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] C_DN = 8'h01;
  localparam logic [7:0] C_IC = 8'h02;
  localparam logic [7:0] C_FZ = 8'h04;
  localparam logic [7:0] C_FC = 8'h08;
  localparam logic [7:0] C_HL = 8'h10;
  localparam logic [7:0] C_EI = 8'h20;
  localparam logic [7:0] C_DI = 8'h40;
  localparam logic [7:0] C_RT = 8'h80;

  // flg = {cb_mode, int_mode, halted, ime}
  typedef struct packed {
    logic       rst;
    logic [7:0] d;
    logic [7:0] ctl;
    logic [1:0] cond;
    logic [2:0] nc;
    logic [4:0] irq;
    logic [7:0] ir;
    logic [2:0] step;
    logic [3:0] flg;
    logic [4:0] ack;
    logic [7:0] vec;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t r(input logic rs, input logic [7:0] d, input logic [7:0] ctl,
                             input logic [1:0] cd, input logic [2:0] nc, input logic [4:0] irq,
                             input logic [7:0] eir, input logic [2:0] est, input logic [3:0] efl,
                             input logic [4:0] eack, input logic [7:0] evec);
    vec_t v;
    v.rst = rs; v.d = d; v.ctl = ctl; v.cond = cd; v.nc = nc; v.irq = irq;
    v.ir = eir; v.step = est; v.flg = efl; v.ack = eack; v.vec = evec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; d_in = v.d;
    done = v.ctl[0]; is_cond = v.ctl[1]; f_z = v.ctl[2]; f_c = v.ctl[3];
    halt_req = v.ctl[4]; ei = v.ctl[5]; di = v.ctl[6]; reti = v.ctl[7];
    cond = v.cond; next_cond = v.nc; irq_pending = v.irq;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    tick();
    e = sb.pop_front();
    chk($sformatf("row%0d ir", idx), ir, e.ir);
    chk($sformatf("row%0d step", idx), 8'(step), 8'(e.step));
    chk($sformatf("row%0d flags", idx), 8'({cb_mode, int_mode, halted, ime}), 8'(e.flg));
    chk($sformatf("row%0d irq_ack", idx), 8'(irq_ack), 8'(e.ack));
    chk($sformatf("row%0d irq_vec", idx), irq_vec, e.vec);
  endtask

  initial begin
    vec_t v;
    int   n;
    // reset with garbage on the bus
    tbl.push_back(r(0, 8'hFF, 0, 0, 0, 5'b00000, 8'h00, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(0, 8'hFF, 0, 0, 0, 5'b00000, 8'h00, 0, 4'b0000, 5'b0, 8'h00));
    // conditional steps and wrap
    tbl.push_back(r(1, 8'h00, C_IC | C_FZ, 0, 3, 5'b0, 8'h00, 3, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h20, C_DN, 0, 0, 5'b0, 8'h20, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, C_IC, 0, 3, 5'b0, 8'h20, 1, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, C_IC, 3, 5, 5'b0, 8'h20, 5, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b0, 8'h20, 6, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b0, 8'h20, 7, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b0, 8'h20, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, C_IC | C_FC, 2, 2, 5'b0, 8'h20, 2, 4'b0000, 5'b0, 8'h00));
    // CB prefix
    tbl.push_back(r(1, 8'hCB, C_DN, 0, 0, 5'b0, 8'hCB, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h37, C_DN, 0, 0, 5'b0, 8'h37, 0, 4'b1000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, C_DN, 0, 0, 5'b0, 8'h00, 0, 4'b0000, 5'b0, 8'h00));
    // EI delay then dispatch of irq 2
    tbl.push_back(r(1, 8'h3C, C_DN | C_EI, 0, 0, 5'b00100, 8'h3C, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b00100, 8'h3C, 1, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'hAA, C_DN, 0, 0, 5'b00100, 8'hAA, 0, 4'b0001, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'hBB, C_DN, 0, 0, 5'b00100, 8'hAA, 0, 4'b0100, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'hCC, C_DN, 0, 0, 5'b00100, 8'hAA, 1, 4'b0100, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'hCC, 0, 0, 0, 5'b00100, 8'hAA, 2, 4'b0100, 5'b00100, 8'h50));
    tbl.push_back(r(1, 8'hCC, 0, 0, 0, 5'b00000, 8'hAA, 3, 4'b0100, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'hCC, 0, 0, 0, 5'b00000, 8'hAA, 4, 4'b0100, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'hC3, 0, 0, 0, 5'b00000, 8'hC3, 0, 4'b0000, 5'b0, 8'h50));
    // HALT with ime=0 wakes without dispatch
    tbl.push_back(r(1, 8'h76, C_DN | C_HL, 0, 0, 5'b0, 8'hC3, 0, 4'b0010, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'h76, 0, 0, 0, 5'b0, 8'hC3, 0, 4'b0010, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'h12, 0, 0, 0, 5'b00001, 8'h12, 0, 4'b0000, 5'b0, 8'h50));
    // HALT with ime=1 dispatches irq 0
    tbl.push_back(r(1, 8'h34, C_DN | C_RT, 0, 0, 5'b0, 8'h34, 0, 4'b0001, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'h76, C_DN | C_HL, 0, 0, 5'b0, 8'h34, 0, 4'b0011, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b00001, 8'h34, 0, 4'b0100, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b00001, 8'h34, 1, 4'b0100, 5'b0, 8'h50));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b00001, 8'h34, 2, 4'b0100, 5'b00001, 8'h40));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b00000, 8'h34, 3, 4'b0100, 5'b0, 8'h40));
    tbl.push_back(r(1, 8'h00, 0, 0, 0, 5'b00000, 8'h34, 4, 4'b0100, 5'b0, 8'h40));
    tbl.push_back(r(1, 8'h56, 0, 0, 0, 5'b00000, 8'h56, 0, 4'b0000, 5'b0, 8'h40));
    // DI on the done blocks a pending irq
    tbl.push_back(r(1, 8'h57, C_DN | C_RT, 0, 0, 5'b0, 8'h57, 0, 4'b0001, 5'b0, 8'h40));
    tbl.push_back(r(1, 8'h58, C_DN | C_DI, 0, 0, 5'b00010, 8'h58, 0, 4'b0000, 5'b0, 8'h40));
    tbl.push_back(r(1, 8'h59, C_DN, 0, 0, 5'b00010, 8'h59, 0, 4'b0000, 5'b0, 8'h40));
    // reset in the middle of dispatch
    tbl.push_back(r(1, 8'h5A, C_DN | C_RT, 0, 0, 5'b0, 8'h5A, 0, 4'b0001, 5'b0, 8'h40));
    tbl.push_back(r(1, 8'h5B, C_DN, 0, 0, 5'b01000, 8'h5A, 0, 4'b0100, 5'b0, 8'h40));
    tbl.push_back(r(1, 8'h5B, 0, 0, 0, 5'b01000, 8'h5A, 1, 4'b0100, 5'b0, 8'h40));
    tbl.push_back(r(1, 8'h5B, 0, 0, 0, 5'b01000, 8'h5A, 2, 4'b0100, 5'b01000, 8'h58));
    tbl.push_back(r(1, 8'h5B, 0, 0, 0, 5'b01000, 8'h5A, 3, 4'b0100, 5'b0, 8'h58));
    tbl.push_back(r(0, 8'h5B, C_DN, 0, 0, 5'b01000, 8'h00, 0, 4'b0000, 5'b0, 8'h00));
    // irq withdrawn before step 2: no ack, vector 00
    tbl.push_back(r(1, 8'h10, C_DN | C_RT, 0, 0, 5'b0, 8'h10, 0, 4'b0001, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h11, C_DN, 0, 0, 5'b00011, 8'h10, 0, 4'b0100, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h11, 0, 0, 0, 5'b0, 8'h10, 1, 4'b0100, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h11, 0, 0, 0, 5'b0, 8'h10, 2, 4'b0100, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h11, 0, 0, 0, 5'b0, 8'h10, 3, 4'b0100, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h11, 0, 0, 0, 5'b0, 8'h10, 4, 4'b0100, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h20, 0, 0, 0, 5'b0, 8'h20, 0, 4'b0000, 5'b0, 8'h00));
    // DI right after EI cancels the pending enable
    tbl.push_back(r(1, 8'h21, C_DN | C_EI, 0, 0, 5'b0, 8'h21, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h22, C_DN | C_DI, 0, 0, 5'b0, 8'h22, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h23, C_DN, 0, 0, 5'b00001, 8'h23, 0, 4'b0000, 5'b0, 8'h00));
    tbl.push_back(r(1, 8'h24, C_DN, 0, 0, 5'b00001, 8'h24, 0, 4'b0000, 5'b0, 8'h00));

    foreach (tbl[i]) apply(i, tbl[i]);

    // HALT with ime=1, irq 4 arrives later: expect vector 60 within budget.
    drive(r(1, 8'h30, C_DN | C_RT, 0, 0, 5'b0, 0, 0, 0, 0, 0));
    tick();
    drive(r(1, 8'h76, C_DN | C_HL, 0, 0, 5'b0, 0, 0, 0, 0, 0));
    tick();
    chk("seq halted", 8'(halted), 8'h01);
    drive(r(1, 8'h77, 0, 0, 0, 5'b10000, 0, 0, 0, 0, 0));
    sb.push_back(r(1, 8'h77, 0, 0, 0, 5'b10000, 8'h77, 0, 4'b0000, 5'b10000, 8'h60));
    n = 0;
    do begin
      tick();
      n++;
    end while (irq_ack == 5'b0 && n < 12);
    v = sb.pop_front();
    chk("seq ack_seen_in_budget", 8'(n < 12), 8'h01);
    chk("seq irq_ack", 8'(irq_ack), 8'(v.ack));
    chk("seq irq_vec", irq_vec, v.vec);
    chk("seq ack_step", 8'(step), 8'h02);
    irq_pending = 5'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (int_mode && n < 12);
    chk("seq int_exit_in_budget", 8'(n < 12), 8'h01);
    chk("seq ir_after_dispatch", ir, v.ir);
    chk("seq flags_after_dispatch", 8'({cb_mode, int_mode, halted, ime}), 8'(v.flg));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
